// File: rtl/sram_read_streamer.sv
// rtl/sram_read_streamer.sv - streams a block of SRAM words out through a 2-entry ready/valid buffer
module sram_read_streamer #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 13,
    parameter int LEN_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_words,
    output logic [ADDR_WIDTH-1:0] radr,
    output logic                  re,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  words_left;
    logic                  inflight;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic                  push;
    logic                  pop;
    logic [2:0]            occ_after;

    // The read issued this cycle lands one cycle later, so it is the push source.
    assign push      = inflight;
    assign out_valid = (count != 2'd0);
    assign out_data  = buf0;
    assign pop       = out_valid & out_ready;
    assign busy      = (state != IDLE);

    // Words already owed to the buffer once this cycle's pop is taken out.
    assign occ_after = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};

    // Issue only when the buffer is guaranteed a free slot on arrival; seeing the
    // same-cycle pop is what lets a continuously-ready consumer get one word per cycle.
    assign re = (state == ISSUE) && (occ_after < 3'd2);

    // Done fires on the final accept, or straight away for an empty transfer.
    assign done = (state == DRAIN) && !inflight &&
                  ((count == 2'd0) || ((count == 2'd1) && pop));

    // Transfer sequencing: address/length capture, issue counting and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            radr       <= '0;
            words_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        radr       <= base_addr;
                        words_left <= num_words;
                        state      <= (num_words == '0) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (re) begin
                        radr       <= radr + ADDR_WIDTH'(1);
                        words_left <= words_left - LEN_WIDTH'(1);
                        if (words_left == LEN_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Track the single outstanding read; reset drops any data still on its way.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= re;
        end
    end

    // Two-entry buffer with buf0 as the registered head; simultaneous push/pop keeps order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            assert (!(push && !pop && (count == 2'd2)));
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        buf0 <= q;
                    end else begin
                        buf1 <= q;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf0  <= buf1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        buf0 <= q;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_read_streamer.sv
// tb/tb_sram_read_streamer.sv - directed self-checking bench for sram_read_streamer
module tb_sram_read_streamer;

    logic         clk;
    logic         rst;
    logic         start;
    logic [12:0]  base_addr;
    logic [13:0]  num_words;
    logic [12:0]  radr;
    logic         re;
    logic [127:0] q;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    int n_checks;
    int n_fails;

    sram_read_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .radr      (radr),
        .re        (re),
        .q         (q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] data_of(input logic [12:0] a);
        logic [31:0] w;
        w = {3'b000, a, 16'hA5C3};
        return {w, ~w, w ^ 32'h5A5A_0F0F, {19'h0, a} * 32'd3};
    endfunction

    // SRAM model: one-cycle read latency
    always @(posedge clk) begin
        if (re) q <= data_of(radr);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ready_at(input int mode, input int c);
        if (mode == 1) return (c % 3 == 0);
        return 1'b1;
    endfunction

    // mode 0: ready high; mode 1: ready 1,0,0 repeating; mode 2: ready high plus a stray start at cycle 2.
    // done_exp < 0 means done must coincide with the last accept.
    task automatic run_xfer(input string tag, input logic [12:0] base, input logic [13:0] n,
                            input int mode, input int done_exp);
        logic [12:0]  exp_addr;
        logic [12:0]  acc_addr;
        logic [127:0] held;
        logic         stalled;
        int n_re, n_acc, first_re, first_vld, last_acc, done_cyc, c, limit;
        int errs_addr, errs_data, errs_stab, errs_busy;
        exp_addr = base; acc_addr = base; held = '0; stalled = 1'b0;
        n_re = 0; n_acc = 0; first_re = -1; first_vld = -1; last_acc = -1; done_cyc = -1;
        errs_addr = 0; errs_data = 0; errs_stab = 0; errs_busy = 0;
        limit = int'(n) * 4 + 20;
        @(negedge clk);
        start = 1'b1; base_addr = base; num_words = n; out_ready = ready_at(mode, 0);
        c = 0;
        while (c < limit) begin
            #1;
            if (re) begin
                if (n_re == 0) first_re = c;
                if (radr !== exp_addr) errs_addr++;
                exp_addr = exp_addr + 13'd1;
                n_re++;
            end
            if (out_valid && first_vld < 0) first_vld = c;
            if (stalled && (out_data !== held)) errs_stab++;
            stalled = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                last_acc = c;
                if (out_data !== data_of(acc_addr)) errs_data++;
                acc_addr = acc_addr + 13'd1;
                n_acc++;
            end
            if (c >= 1 && !busy) errs_busy++;
            if (done) done_cyc = c;
            @(negedge clk);
            c++;
            start = (mode == 2 && c == 2);
            base_addr = (mode == 2 && c == 2) ? 13'h0AAA : base;
            num_words = (mode == 2 && c == 2) ? 14'd5 : n;
            out_ready = ready_at(mode, c);
            if (done_cyc >= 0) break;
        end
        #1;
        check_eq({tag, "_re_count"}, n_re, n);
        check_eq({tag, "_acc_count"}, n_acc, n);
        check_eq({tag, "_addr_seq"}, errs_addr, 0);
        check_eq({tag, "_data_order"}, errs_data, 0);
        check_eq({tag, "_stable"}, errs_stab, 0);
        check_eq({tag, "_busy_during"}, errs_busy, 0);
        if (n != 0) begin
            check_eq({tag, "_first_re"}, first_re, 1);
            check_eq({tag, "_first_valid"}, first_vld, 3);
        end else begin
            check_eq({tag, "_no_valid"}, first_vld, -1);
        end
        check_eq({tag, "_done_cycle"}, done_cyc, (done_exp < 0) ? last_acc : done_exp);
        check_eq({tag, "_busy_after"}, busy, 1'b0);
        check_eq({tag, "_done_after"}, done, 1'b0);
    endtask

    initial begin
        int bad;
        n_checks = 0; n_fails = 0;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_re", re, 1'b0);
        check_eq("rst_radr", radr, 13'h0);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_data", out_data, 128'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        rst = 1'b0;

        run_xfer("basic4", 13'h0010, 14'd4, 0, 6);
        run_xfer("wrap3", 13'h1FFE, 14'd3, 0, 5);
        run_xfer("stall8", 13'h0040, 14'd8, 1, -1);
        run_xfer("zero", 13'h0123, 14'd0, 0, 1);
        run_xfer("restart_ignored", 13'h0020, 14'd6, 2, 8);

        // reset while a read is in flight
        @(negedge clk);
        start = 1'b1; base_addr = 13'h0100; num_words = 14'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        check_eq("midrst_re_before", re, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_re", re, 1'b0);
        check_eq("midrst_radr", radr, 13'h0);
        check_eq("midrst_valid", out_valid, 1'b0);
        check_eq("midrst_data", out_data, 128'h0);
        check_eq("midrst_busy", busy, 1'b0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid || done || re) bad++;
            @(negedge clk);
            #1;
        end
        check_eq("midrst_quiet", bad, 0);
        run_xfer("after_rst", 13'h0200, 14'd5, 0, 7);

        run_xfer("full8192", 13'h0000, 14'd8192, 0, 8194);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sram_read_streamer.md
SRAM_READ_STREAMER -- requirements
Module: sram_read_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, the SRAM word and output stream width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 13, the SRAM word-address width (8192 words).
REQ-003 SHALL have parameter LEN_WIDTH, default 14, the transfer-length width (0..8192 words).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_WIDTH  first word address, captured on an accepted start.
REQ-008 num_words  input  LEN_WIDTH  word count, captured on an accepted start.
REQ-009 radr  output  ADDR_WIDTH  SRAM read address.
REQ-010 re  output  1  SRAM read enable.
REQ-011 q  input  DATA_WIDTH  SRAM read data, valid in the cycle after re was high.
REQ-012 out_data  output  DATA_WIDTH  stream data.
REQ-013 out_valid  output  1  stream valid.
REQ-014 out_ready  input  1  stream ready from the consumer.
REQ-015 busy  output  1  high from the accepted start until the done cycle, inclusive.
REQ-016 done  output  1  one-cycle pulse when the transfer completes.

Function
REQ-017 SHALL implement the states IDLE, ISSUE and DRAIN.
REQ-018 IDLE->ISSUE on start with num_words!=0; IDLE->DRAIN on start with num_words==0.
REQ-019 ISSUE->DRAIN in the cycle the last read is issued; DRAIN->IDLE when no read is in flight, the buffer is empty and the last word was accepted.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 re SHALL be driven high in ISSUE only when (buffer_count + inflight - pop) < 2, where pop = out_valid & out_ready in the same cycle.
REQ-022 radr SHALL equal base_addr for the first read and increment by 1 per issued read, wrapping modulo 2^ADDR_WIDTH (0x1FFF -> 0x0000).
REQ-023 inflight SHALL be a 1-bit flag set by re and cleared the next cycle; q SHALL be written into the buffer in that next cycle.
REQ-024 SHALL use a 2-entry FIFO output buffer; out_data/out_valid SHALL come from the FIFO head register, never combinationally from q.
REQ-025 A push and a pop in the same cycle SHALL leave the count unchanged and preserve word order.
REQ-026 The credit rule SHALL make overflow impossible; a push into a full buffer is a design error, flagged by a simulation assertion.
REQ-027 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 Latency: start accepted in cycle 0 -> re high in cycle 1 -> out_valid high in cycle 3.
REQ-029 With out_ready held high, SHALL sustain one word per cycle after the first.
REQ-030 done SHALL pulse in the cycle the last word is accepted (num_words>0), or 1 cycle after the accepted start (num_words==0); busy falls the following cycle.
REQ-031 The word counter SHALL count num_words issues exactly; num_words=8192 SHALL read every address once.

Reset
REQ-032 On rst: state=IDLE, re=0, radr=0, out_valid=0, out_data=0, busy=0, done=0, buffer_count=0, inflight=0.
REQ-033 Reset mid-transfer SHALL abort the transfer immediately; q arriving the cycle after reset SHALL be discarded, and no done pulse SHALL be produced.

Verification
REQ-034 base_addr=0x010, num_words=4, out_ready=1 -> re cycles 1-4 at radr 0x010..0x013; out_valid cycles 3-6 with data in address order; done in cycle 6.
REQ-035 base_addr=0x1FFE, num_words=3 -> reads at 0x1FFE, 0x1FFF, 0x0000; three words out in that order.
REQ-036 num_words=8, out_ready toggling 1,0,0,1,... -> never more than 2 words buffered, no loss or duplication, data stable while stalled, done on the 8th accept.
REQ-037 num_words=0 -> no re pulses, out_valid stays 0, done in cycle 1.
REQ-038 rst asserted mid-transfer with a read in flight -> all outputs reach reset values the next cycle, no done; a new start then runs normally.
REQ-039 start pulsed again while busy -> ignored; the original transfer completes unchanged.
